// File: rtl/retry_lrsm.sv
// ============================================================================
// Module   : retry_lrsm
// Purpose  : Link-layer retry state machine. Sequences RETRY.Req, waits for a
//            matching RETRY.Ack, escalates to PHY re-init at the retry limit,
//            and aborts after the re-init budget is spent.
// Options  : `define RETRY_LRSM_TIMEOUT_EN adds a LOCAL_IDLE ack-wait timer
//            that re-issues RETRY.Req after TIMEOUT_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retry_lrsm #(
  parameter int unsigned MAX_NUM_RETRY      = 10,
  parameter int unsigned MAX_NUM_PHY_REINIT = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_error_detected,
  input  logic       i_llrreq_sent,
  input  logic       i_retry_ack_valid,
  input  logic       i_num_retry_matches,
  input  logic [4:0] i_retry_num,
  input  logic       i_phy_reinit_done,
  output logic       o_send_llrreq,
  output logic       o_num_retry_inc_en,
  output logic       o_num_retry_reset,
  output logic       o_phy_reinit_req,
  output logic       o_retry_abort,
  output logic [2:0] o_lrsm_state,
  output logic [3:0] o_num_phy_reinit
);

  // Parameter range guards, evaluated at elaboration.
  if (MAX_NUM_RETRY < 1 || MAX_NUM_RETRY > 31) begin : g_bad_max_retry
    $error("retry_lrsm: MAX_NUM_RETRY out of range 1..31");
  end
  if (MAX_NUM_PHY_REINIT < 1 || MAX_NUM_PHY_REINIT > 15) begin : g_bad_max_reinit
    $error("retry_lrsm: MAX_NUM_PHY_REINIT out of range 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("retry_lrsm: TIMEOUT_CYCLES out of range 2..65535");
  end

  localparam logic [4:0] c_MAX_RETRY  = 5'(MAX_NUM_RETRY);
  localparam logic [3:0] c_MAX_REINIT = 4'(MAX_NUM_PHY_REINIT);

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_LLRREQ     = 3'd1,
    ST_LOCAL_IDLE = 3'd2,
    ST_PHY_REINIT = 3'd3,
    ST_ABORT      = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] num_phy_reinit_q, num_phy_reinit_d;
  logic       w_timeout;

`ifdef RETRY_LRSM_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q, timer_d;

  assign w_timeout = (timer_q == c_TIMEOUT_LAST);

  // Timer runs only while staying in LOCAL_IDLE; any entry starts it from zero.
  always_comb begin
    timer_d = '0;
    if (state_q == ST_LOCAL_IDLE && state_d == ST_LOCAL_IDLE) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Ack-wait timer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State and re-init counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= ST_NORMAL;
      num_phy_reinit_q <= '0;
    end else begin
      state_q          <= state_d;
      num_phy_reinit_q <= num_phy_reinit_d;
    end
  end

  // Next-state and Mealy-style request outputs.
  always_comb begin
    state_d            = state_q;
    num_phy_reinit_d   = num_phy_reinit_q;
    o_send_llrreq      = 1'b0;
    o_num_retry_inc_en = 1'b0;
    o_num_retry_reset  = 1'b0;
    o_phy_reinit_req   = 1'b0;
    o_retry_abort      = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (i_error_detected) begin
          state_d = ST_LLRREQ;
        end
      end

      ST_LLRREQ: begin
        if (i_retry_num >= c_MAX_RETRY) begin
          // Retry budget exhausted: escalate to PHY re-init or give up.
          if (num_phy_reinit_q == c_MAX_REINIT) begin
            state_d = ST_ABORT;
          end else begin
            num_phy_reinit_d = num_phy_reinit_q + 4'd1;
            state_d          = ST_PHY_REINIT;
          end
        end else begin
          o_send_llrreq = 1'b1;
          if (i_llrreq_sent) begin
            o_num_retry_inc_en = 1'b1;
            state_d            = ST_LOCAL_IDLE;
          end
        end
      end

      ST_LOCAL_IDLE: begin
        // A matching ack takes priority over a coincident timeout.
        if (i_retry_ack_valid && i_num_retry_matches) begin
          o_num_retry_reset = 1'b1;
          num_phy_reinit_d  = '0;
          state_d           = ST_NORMAL;
        end else if (w_timeout) begin
          state_d = ST_LLRREQ;
        end
      end

      ST_PHY_REINIT: begin
        o_phy_reinit_req = 1'b1;
        if (i_phy_reinit_done) begin
          o_num_retry_reset = 1'b1;
          state_d           = ST_LLRREQ;
        end
      end

      ST_ABORT: begin
        o_retry_abort = 1'b1;
      end

      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  assign o_lrsm_state     = state_q;
  assign o_num_phy_reinit = num_phy_reinit_q;

endmodule

`default_nettype wire

// File: tb/tb_retry_lrsm.sv
// ============================================================================
// Module   : tb_retry_lrsm
// Purpose  : Directed scoreboard bench for retry_lrsm. Each stimulus cycle
//            queues its hand-computed expected state/outputs; a monitor pops
//            and compares on the falling edge of the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retry_lrsm;

  logic       clk;
  logic       rst_n;
  logic       err;
  logic       sent;
  logic       ack;
  logic       mat;
  logic [4:0] rnum;
  logic       done;
  logic       send_llrreq;
  logic       inc_en;
  logic       rst_pulse;
  logic       reinit_req;
  logic       abort;
  logic [2:0] state;
  logic [3:0] nphy;

  retry_lrsm #(
    .MAX_NUM_RETRY      (10),
    .MAX_NUM_PHY_REINIT (3),
    .TIMEOUT_CYCLES     (8)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_error_detected    (err),
    .i_llrreq_sent       (sent),
    .i_retry_ack_valid   (ack),
    .i_num_retry_matches (mat),
    .i_retry_num         (rnum),
    .i_phy_reinit_done   (done),
    .o_send_llrreq       (send_llrreq),
    .o_num_retry_inc_en  (inc_en),
    .o_num_retry_reset   (rst_pulse),
    .o_phy_reinit_req    (reinit_req),
    .o_retry_abort       (abort),
    .o_lrsm_state        (state),
    .o_num_phy_reinit    (nphy)
  );

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [4:0] o;   // {send_llrreq, inc_en, retry_reset, reinit_req, abort}
    logic [3:0] np;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue what the
  // DUT must show during that cycle.
  task automatic cyc(input string tag, input logic rstn, input logic e,
                     input logic s, input logic a, input logic m,
                     input logic d, input logic [4:0] rn,
                     input logic [2:0] st, input logic [4:0] o,
                     input logic [3:0] np);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rstn;
    err   = e;
    sent  = s;
    ack   = a;
    mat   = m;
    done  = d;
    rnum  = rn;
    x.tag = tag;
    x.st  = st;
    x.o   = o;
    x.np  = np;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      checks++;
      if (state !== mon_x.st ||
          {send_llrreq, inc_en, rst_pulse, reinit_req, abort} !== mon_x.o ||
          nphy !== mon_x.np) begin
        errors++;
        $display("FAIL %s: got state=%0d outs=%b nphy=%0d, want state=%0d outs=%b nphy=%0d",
                 mon_x.tag, state,
                 {send_llrreq, inc_en, rst_pulse, reinit_req, abort}, nphy,
                 mon_x.st, mon_x.o, mon_x.np);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    err   = 1'b0;
    sent  = 1'b0;
    ack   = 1'b0;
    mat   = 1'b0;
    done  = 1'b0;
    rnum  = 5'd0;

    // Reset: everything idle even with inputs active.
    cyc("rst0", 0, 0, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);
    cyc("rst1", 0, 1, 1, 1, 1, 1, 5'd0, 3'd0, 5'b00000, 4'd0);

    // Basic retry: 0 -> 1 -> 2 -> 0, one inc pulse, one reset pulse.
    cyc("t1_err",   1, 1, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);
    cyc("t1_req0",  1, 0, 0, 0, 0, 0, 5'd0, 3'd1, 5'b10000, 4'd0);
    cyc("t1_req1",  1, 0, 0, 0, 0, 0, 5'd0, 3'd1, 5'b10000, 4'd0);
    cyc("t1_sent",  1, 0, 1, 0, 0, 0, 5'd0, 3'd1, 5'b11000, 4'd0);
    cyc("t1_idle0", 1, 1, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t1_idle1", 1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t1_idle2", 1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t1_idle3", 1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t1_ack",   1, 0, 0, 1, 1, 0, 5'd1, 3'd2, 5'b00100, 4'd0);
    cyc("t1_norm",  1, 0, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);

    // Non-matching ack ignored, matching ack completes.
    cyc("t2_err",     1, 1, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);
    cyc("t2_sent",    1, 0, 1, 0, 0, 0, 5'd0, 3'd1, 5'b11000, 4'd0);
    cyc("t2_nomatch", 1, 0, 0, 1, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t2_wait",    1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t2_ack",     1, 0, 0, 1, 1, 0, 5'd1, 3'd2, 5'b00100, 4'd0);
    cyc("t2_norm",    1, 0, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);

    // No ack: with the timer, LLRREQ after 8 idle cycles; without, keep waiting.
    cyc("t3_err",  1, 1, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);
    cyc("t3_sent", 1, 0, 1, 0, 0, 0, 5'd0, 3'd1, 5'b11000, 4'd0);
    for (int i = 0; i < 8; i++) begin
      cyc("t3_idle", 1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    end
`ifdef RETRY_LRSM_TIMEOUT_EN
    cyc("t3_toreq",  1, 0, 0, 0, 0, 0, 5'd1, 3'd1, 5'b10000, 4'd0);
    cyc("t3_resent", 1, 0, 1, 0, 0, 0, 5'd1, 3'd1, 5'b11000, 4'd0);
    cyc("t3_ack",    1, 0, 0, 1, 1, 0, 5'd2, 3'd2, 5'b00100, 4'd0);
`else
    cyc("t3_wait0",  1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t3_wait1",  1, 0, 0, 0, 0, 0, 5'd1, 3'd2, 5'b00000, 4'd0);
    cyc("t3_ack",    1, 0, 0, 1, 1, 0, 5'd1, 3'd2, 5'b00100, 4'd0);
`endif
    cyc("t3_norm", 1, 0, 0, 0, 0, 0, 5'd0, 3'd0, 5'b00000, 4'd0);

    // Retry limit -> PHY re-init three times, fourth hit aborts.
    cyc("t4_err",    1, 1, 0, 0, 0, 0, 5'd10, 3'd0, 5'b00000, 4'd0);
    cyc("t4_lim1",   1, 0, 0, 0, 0, 0, 5'd10, 3'd1, 5'b00000, 4'd0);
    cyc("t4_reinit", 1, 0, 0, 0, 0, 0, 5'd10, 3'd3, 5'b00010, 4'd1);
    cyc("t4_done1",  1, 0, 0, 0, 0, 1, 5'd10, 3'd3, 5'b00110, 4'd1);
    cyc("t4_lim2",   1, 0, 1, 0, 0, 0, 5'd10, 3'd1, 5'b00000, 4'd1);
    cyc("t4_done2",  1, 0, 0, 0, 0, 1, 5'd10, 3'd3, 5'b00110, 4'd2);
    cyc("t4_lim3",   1, 0, 0, 0, 0, 0, 5'd10, 3'd1, 5'b00000, 4'd2);
    cyc("t4_done3",  1, 0, 0, 0, 0, 1, 5'd10, 3'd3, 5'b00110, 4'd3);
    cyc("t4_lim4",   1, 0, 0, 0, 0, 0, 5'd10, 3'd1, 5'b00000, 4'd3);
    cyc("t4_abort",  1, 1, 1, 1, 1, 1, 5'd0,  3'd4, 5'b00001, 4'd3);
    cyc("t4_hold",   1, 1, 0, 0, 0, 0, 5'd0,  3'd4, 5'b00001, 4'd3);
    cyc("t4_rst",    0, 0, 0, 0, 0, 0, 5'd0,  3'd0, 5'b00000, 4'd0);

    // Matching ack clears re-init count; async reset mid LOCAL_IDLE.
    cyc("t5_err",     1, 1, 0, 0, 0, 0, 5'd0,  3'd0, 5'b00000, 4'd0);
    cyc("t5_lim",     1, 0, 0, 0, 0, 0, 5'd10, 3'd1, 5'b00000, 4'd0);
    cyc("t5_done",    1, 0, 0, 0, 0, 1, 5'd10, 3'd3, 5'b00110, 4'd1);
    cyc("t5_sent",    1, 0, 1, 0, 0, 0, 5'd0,  3'd1, 5'b11000, 4'd1);
    cyc("t5_ack",     1, 0, 0, 1, 1, 0, 5'd1,  3'd2, 5'b00100, 4'd1);
    cyc("t5_clr",     1, 1, 0, 0, 0, 0, 5'd0,  3'd0, 5'b00000, 4'd0);
    cyc("t5_lim2",    1, 0, 0, 0, 0, 0, 5'd10, 3'd1, 5'b00000, 4'd0);
    cyc("t5_reinit",  1, 0, 0, 0, 0, 0, 5'd10, 3'd3, 5'b00010, 4'd1);
    cyc("t5_done2",   1, 0, 0, 0, 0, 1, 5'd10, 3'd3, 5'b00110, 4'd1);
    cyc("t5_sent2",   1, 0, 1, 0, 0, 0, 5'd0,  3'd1, 5'b11000, 4'd1);
    cyc("t5_idle",    1, 0, 0, 0, 0, 0, 5'd1,  3'd2, 5'b00000, 4'd1);
    cyc("t5_arst",    0, 0, 0, 1, 1, 0, 5'd1,  3'd0, 5'b00000, 4'd0);
    cyc("t5_release", 1, 0, 0, 0, 0, 0, 5'd0,  3'd0, 5'b00000, 4'd0);
    cyc("t5_quiet",   1, 0, 0, 0, 0, 0, 5'd0,  3'd0, 5'b00000, 4'd0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
